// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared definitions for the SPI command queue: FSM state
//                encoding and default word width / FIFO depth.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int c_DEFAULT_DATA_W = 16;
    localparam int c_DEFAULT_DEPTH  = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. Pointers carry one
//                extra bit so full and empty are told apart without a counter.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_full,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW:0]     r_wr_ptr;
    logic [c_AW:0]     r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    // A write while full or a read while empty is silently dropped
    assign w_push    = i_wr_en & ~o_full;
    assign w_pop     = i_rd_en & ~o_empty;
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[c_AW-1:0]];

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
        end
    end

    // Pointer update; natural binary overflow gives the modulo-DEPTH wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_queue
//  Description : Queues command words for an SPI master, issues one transfer
//                at a time with a start pulse, captures the reply into an RX
//                FIFO and inserts a programmable idle gap between transfers.
//  Options     : SPI_CMD_QUEUE_TIMEOUT_EN - adds a WAIT_DONE watchdog that
//                abandons a stuck transfer and raises a sticky Timeout flag.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_cmd_queue
    import spi_pkg::*;
#(
    parameter int DATA_W         = c_DEFAULT_DATA_W,
    parameter int DEPTH          = c_DEFAULT_DEPTH,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              CLK_IN,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [DATA_W-1:0] Tx_Data,
    input  logic              Tx_Valid,
    output logic              Tx_Ready,
    output logic [DATA_W-1:0] Rx_Data,
    output logic              Rx_Valid,
    input  logic              Rx_Ready,
    output logic [DATA_W-1:0] Master_TxData,
    output logic              StartFlag,
    input  logic [DATA_W-1:0] Master_RxData,
    input  logic              SPI_Done,
    output logic              Busy,
    output logic              Timeout
);

`ifdef SPI_CMD_QUEUE_TIMEOUT_EN
    localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_CNT_W = (c_TO_W > 8) ? c_TO_W : 8;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
`else
    localparam int c_CNT_W = 8;
`endif
    // A zero-length gap still occupies the GAP state for one cycle
    localparam logic [c_CNT_W-1:0] c_GAP_LAST =
        c_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    // Elaboration-time parameter sanity checks
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("spi_cmd_queue: DEPTH must be a power of two >= 2");
    end
    if ((GAP_CYCLES < 0) || (GAP_CYCLES > 255)) begin : g_bad_gap
        $error("spi_cmd_queue: GAP_CYCLES must be in 0..255");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("spi_cmd_queue: TIMEOUT_CYCLES must be >= 2");
    end

    state_t              r_state;
    state_t              w_next_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_done_d;
    logic                w_done_rise;
    logic                w_tx_full;
    logic                w_tx_empty;
    logic                w_rx_full;
    logic                w_rx_empty;
    logic                w_tx_pop;
    logic                w_rx_push;
    logic [DATA_W-1:0]   w_tx_head;
    logic [DATA_W-1:0]   r_tx_word;

    assign w_done_rise   = SPI_Done & ~r_done_d;
    assign Tx_Ready      = ~w_tx_full;
    assign Rx_Valid      = ~w_rx_empty;
    assign Master_TxData = r_tx_word;

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (CLK_IN),
        .rst_n     (RST_N),
        .i_wr_en   (Tx_Valid),
        .i_wr_data (Tx_Data),
        .o_full    (w_tx_full),
        .i_rd_en   (w_tx_pop),
        .o_rd_data (w_tx_head),
        .o_empty   (w_tx_empty)
    );

    spi_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (CLK_IN),
        .rst_n     (RST_N),
        .i_wr_en   (w_rx_push),
        .i_wr_data (Master_RxData),
        .o_full    (w_rx_full),
        .i_rd_en   (Rx_Ready),
        .o_rd_data (Rx_Data),
        .o_empty   (w_rx_empty)
    );

    // State register plus the SPI_Done history used for edge detection
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_done_d <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_done_d <= SPI_Done;
        end
    end

    // Next-state decode and Moore outputs
    always_comb begin
        w_next_state = r_state;
        w_tx_pop     = 1'b0;
        w_rx_push    = 1'b0;
        StartFlag    = 1'b0;
        Busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                // RX space is reserved here so CAPTURE never has to stall
                if (EN && !w_tx_empty && !w_rx_full) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                w_tx_pop     = 1'b1;
                w_next_state = ST_START;
            end
            ST_START: begin
                StartFlag    = 1'b1;
                w_next_state = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (w_done_rise) begin
                    w_next_state = ST_CAPTURE;
                end
`ifdef SPI_CMD_QUEUE_TIMEOUT_EN
                else if (r_cnt == c_TO_LAST) begin
                    w_next_state = ST_GAP;
                end
`endif
            end
            ST_CAPTURE: begin
                w_rx_push    = 1'b1;
                w_next_state = ST_GAP;
            end
            ST_GAP: begin
                if (r_cnt == c_GAP_LAST) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Shared gap/watchdog counter: cleared on every state change
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (r_state != w_next_state) begin
            r_cnt <= '0;
`ifdef SPI_CMD_QUEUE_TIMEOUT_EN
        end else if ((r_state == ST_GAP) || (r_state == ST_WAIT_DONE)) begin
`else
        end else if (r_state == ST_GAP) begin
`endif
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Word presented to the master, held from LOAD until the next LOAD
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_tx_word <= '0;
        end else if (w_tx_pop) begin
            r_tx_word <= w_tx_head;
        end
    end

`ifdef SPI_CMD_QUEUE_TIMEOUT_EN
    logic r_timeout;

    // Sticky watchdog flag; a done edge on the last cycle still wins
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            r_timeout <= 1'b0;
        end else if ((r_state == ST_WAIT_DONE) && !w_done_rise && (r_cnt == c_TO_LAST)) begin
            r_timeout <= 1'b1;
        end
    end

    assign Timeout = r_timeout;
`else
    assign Timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_cmd_queue
//  Description : Self-checking bench for spi_cmd_queue. A loopback SPI slave
//                answers each start with (word ^ 16'h5900) after a random or
//                fixed latency; queues model the expected TX and RX streams.
//  Options     : SPI_CMD_QUEUE_TIMEOUT_EN - also exercises the watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_cmd_queue;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int GAP   = 4;
    localparam int TO    = 16;

    logic          CLK_IN = 1'b0;
    logic          RST_N;
    logic          EN;
    logic [DW-1:0] Tx_Data;
    logic          Tx_Valid;
    logic          Tx_Ready;
    logic [DW-1:0] Rx_Data;
    logic          Rx_Valid;
    logic          Rx_Ready;
    logic [DW-1:0] Master_TxData;
    logic          StartFlag;
    logic [DW-1:0] Master_RxData;
    logic          SPI_Done;
    logic          Busy;
    logic          Timeout;

    spi_cmd_queue #(
        .DATA_W(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK_IN        (CLK_IN),
        .RST_N         (RST_N),
        .EN            (EN),
        .Tx_Data       (Tx_Data),
        .Tx_Valid      (Tx_Valid),
        .Tx_Ready      (Tx_Ready),
        .Rx_Data       (Rx_Data),
        .Rx_Valid      (Rx_Valid),
        .Rx_Ready      (Rx_Ready),
        .Master_TxData (Master_TxData),
        .StartFlag     (StartFlag),
        .Master_RxData (Master_RxData),
        .SPI_Done      (SPI_Done),
        .Busy          (Busy),
        .Timeout       (Timeout)
    );

    always #5 CLK_IN = ~CLK_IN;

    int cyc = 0;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    // Reference model state
    logic [DW-1:0] exp_tx[$];
    logic [DW-1:0] exp_rx[$];
    int            start_cyc[$];
    int            n_written = 0;
    int            n_starts  = 0;
    int            n_rx      = 0;
    int            wr_cyc    = 0;
    int            fixed_lat = 0;
    bit            hang      = 1'b0;
    int            rd_mode   = 0;   // 0 none, 1 random, 2 always
    bit            rd_single = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        int occ;
        for (int i = 0; i < 400 && (n_written - n_starts) >= DEPTH; i++) @(negedge CLK_IN);
        occ = n_written - n_starts;
        check("tx_room_wait", 32'(occ < DEPTH), 1);
        check("tx_ready_room", Tx_Ready, 1);
        Tx_Valid = 1'b1;
        Tx_Data  = w;
        exp_tx.push_back(w);
        n_written++;
        wr_cyc = cyc;
        @(negedge CLK_IN);
        Tx_Valid = 1'b0;
    endtask

    task automatic wait_rx_count(input string tag, input int target);
        for (int i = 0; i < 3000 && n_rx < target; i++) @(negedge CLK_IN);
        check(tag, n_rx, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  Busy, 0);
        check({tag, "_start"}, StartFlag, 0);
        check({tag, "_txd"},   Master_TxData, 0);
        check({tag, "_txrdy"}, Tx_Ready, 1);
        check({tag, "_rxv"},   Rx_Valid, 0);
        check({tag, "_to"},    Timeout, 0);
    endtask

    // Loopback SPI slave: answers each start, checks the word being sent
    initial begin
        logic [DW-1:0] s_word;
        int            s_lat;
        SPI_Done      = 1'b0;
        Master_RxData = '0;
        forever begin
            @(negedge CLK_IN);
            if (RST_N && StartFlag) begin
                n_starts++;
                start_cyc.push_back(cyc);
                check("start_expected", 32'(exp_tx.size() != 0), 1);
                if (exp_tx.size() != 0) check("start_word", Master_TxData, exp_tx.pop_front());
                s_word = Master_TxData;
                if (!hang) begin
                    s_lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
                    for (int i = 0; i < s_lat; i++) begin
                        @(negedge CLK_IN);
                        check("tx_hold", Master_TxData, s_word);
                        check("start_once", StartFlag, 0);
                    end
                    SPI_Done      = 1'b1;
                    Master_RxData = s_word ^ 16'h5900;
                    exp_rx.push_back(s_word ^ 16'h5900);
                    @(negedge CLK_IN);
                    SPI_Done = 1'b0;
                end
            end
        end
    end

    // RX reader: pops according to rd_mode and checks order/content
    initial begin
        Rx_Ready = 1'b0;
        forever begin
            @(negedge CLK_IN);
            Rx_Ready = (rd_mode == 2) || ((rd_mode == 1) && ($urandom_range(0, 1) == 1)) ||
                       (rd_single && Rx_Valid);
            if (RST_N && Rx_Ready && Rx_Valid) begin
                rd_single = 1'b0;
                check("rx_expected", 32'(exp_rx.size() != 0), 1);
                if (exp_rx.size() != 0) check("rx_word", Rx_Data, exp_rx.pop_front());
                n_rx++;
            end
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d expected=finish", cyc);
        $fatal(1, "time limit");
    end

    // Directed sequence
    initial begin
        int b;
        RST_N    = 1'b0;
        EN       = 1'b0;
        Tx_Valid = 1'b0;
        Tx_Data  = '0;
        #2;
        check_reset_outputs("reset");
        repeat (3) @(negedge CLK_IN);
        RST_N = 1'b1;
        @(negedge CLK_IN);

        // Single transfer: A9A5 out, F0A5 back
        EN        = 1'b1;
        fixed_lat = 4;
        write_word(16'hA9A5);
        for (int i = 0; i < 20 && n_starts < 1; i++) @(negedge CLK_IN);
        check("first_start", n_starts, 1);
        // StartFlag rises on the second clock edge after the write edge
        if (n_starts >= 1) check("start_latency", start_cyc[0] - wr_cyc, 3);
        for (int i = 0; i < 40 && !Rx_Valid; i++) @(negedge CLK_IN);
        check("rx_valid_a", Rx_Valid, 1);
        check("rx_data_a", Rx_Data, 16'hF0A5);
        rd_single = 1'b1;
        wait_rx_count("rx_pop_a", 1);

        // Fill TX with EN low, full write dropped, then RX fills and blocks
        EN        = 1'b0;
        fixed_lat = 0;
        b         = n_starts;
        for (int k = 0; k < DEPTH; k++) write_word(16'h1000 + 16'(k));
        check("tx_full_drop", Tx_Ready, 0);
        Tx_Valid = 1'b1;
        Tx_Data  = 16'hDEAD;
        @(negedge CLK_IN);
        Tx_Valid = 1'b0;
        EN       = 1'b1;
        write_word(16'h1008);
        for (int i = 0; i < 600 && !((n_starts == b + DEPTH) && !Busy); i++) @(negedge CLK_IN);
        repeat (12) @(negedge CLK_IN);
        check("burst_starts", n_starts, b + DEPTH);
        check("burst_rx_valid", Rx_Valid, 1);
        check("burst_blocked_idle", Busy, 0);
        check("burst_tx_ready", Tx_Ready, 1);
        rd_single = 1'b1;
        for (int i = 0; i < 40 && n_starts < b + DEPTH + 1; i++) @(negedge CLK_IN);
        check("ninth_after_pop", n_starts, b + DEPTH + 1);
        rd_mode = 1;
        wait_rx_count("burst_drain", n_written);

        // Start-to-start period with back-to-back queued words
        rd_mode   = 2;
        EN        = 1'b0;
        fixed_lat = 3;
        write_word(16'h2222);
        write_word(16'h3333);
        b  = n_starts;
        EN = 1'b1;
        for (int i = 0; i < 100 && n_starts < b + 2; i++) @(negedge CLK_IN);
        check("period_starts", n_starts, b + 2);
        if (n_starts >= b + 2) check("period", start_cyc[b + 1] - start_cyc[b], 3 + GAP + 4);
        wait_rx_count("period_drain", n_written);

        // EN low holds three words; EN drop mid-transfer does not abort
        rd_mode   = 1;
        fixed_lat = 5;
        EN        = 1'b0;
        b         = n_starts;
        write_word(16'h4444);
        write_word(16'h5555);
        write_word(16'h6666);
        repeat (10) @(negedge CLK_IN);
        check("en_hold_starts", n_starts, b);
        check("en_hold_busy", Busy, 0);
        EN = 1'b1;
        for (int i = 0; i < 20 && n_starts < b + 1; i++) @(negedge CLK_IN);
        EN = 1'b0;
        wait_rx_count("en_drop_completes", n_written - 2);
        repeat (15) @(negedge CLK_IN);
        check("en_drop_no_next", n_starts, b + 1);
        EN = 1'b1;
        wait_rx_count("en_resume_drain", n_written);

        // Randomised traffic
        fixed_lat = 0;
        for (int k = 0; k < 24; k++) begin
            write_word(16'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge CLK_IN);
        end
        wait_rx_count("random_drain", n_written);
        repeat (12) @(negedge CLK_IN);
        check("random_idle_busy", Busy, 0);
        check("random_idle_rxv", Rx_Valid, 0);
        check("random_idle_txrdy", Tx_Ready, 1);

        // Reset during WAIT_DONE
        rd_mode = 0;
        hang    = 1'b1;
        b       = n_starts;
        write_word(16'h1234);
        for (int i = 0; i < 20 && n_starts < b + 1; i++) @(negedge CLK_IN);
        repeat (2) @(negedge CLK_IN);
        check("midreset_busy_before", Busy, 1);
        #2 RST_N = 1'b0;
        #1 check_reset_outputs("midreset");
        @(negedge CLK_IN);
        RST_N = 1'b1;
        hang  = 1'b0;
        repeat (20) @(negedge CLK_IN);
        check("midreset_no_capture", Rx_Valid, 0);
        check("midreset_no_restart", n_starts, b + 1);

`ifdef SPI_CMD_QUEUE_TIMEOUT_EN
        // Watchdog: SPI_Done never arrives
        hang = 1'b1;
        b    = n_starts;
        write_word(16'h7777);
        for (int i = 0; i < 20 && n_starts < b + 1; i++) @(negedge CLK_IN);
        check("to_start", n_starts, b + 1);
        if (n_starts >= b + 1) begin
            for (int i = 0; i < 100 && cyc < start_cyc[b] + TO; i++) @(negedge CLK_IN);
            check("to_not_yet", Timeout, 0);
            @(negedge CLK_IN);
            check("to_set", Timeout, 1);
        end
        repeat (GAP + 4) @(negedge CLK_IN);
        check("to_idle", Busy, 0);
        check("to_no_rx", Rx_Valid, 0);
        check("to_sticky", Timeout, 1);
        #2 RST_N = 1'b0;
        #1 check("to_reset", Timeout, 0);
        @(negedge CLK_IN);
        RST_N = 1'b1;
        hang  = 1'b0;
`endif

        repeat (4) @(negedge CLK_IN);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_cmd_queue.md
SPI_CMD_QUEUE -- requirements
Module: spi_cmd_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 16: SPI word width, matching the master's Master_TxData/Master_RxData.
REQ-002 SHALL have parameter DEPTH, default 8: entries per FIFO; power of two, at least 2.
REQ-003 SHALL have parameter GAP_CYCLES, default 4: idle CLK_IN cycles between consecutive transfers, range 0..255.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096: WAIT_DONE watchdog limit; used only when the timeout macro is defined.
REQ-005 SHALL have ports, one per line: name, direction, width, meaning.
- CLK_IN  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  queue enable; 0 inhibits new transfer starts.
- Tx_Data  in  DATA_W  write word.
- Tx_Valid  in  1  write request.
- Tx_Ready  out  1  TX FIFO not full.
- Rx_Data  out  DATA_W  received word at RX FIFO head.
- Rx_Valid  out  1  RX FIFO not empty.
- Rx_Ready  in  1  read acknowledge.
- Master_TxData  out  DATA_W  word to the SPI master, held stable for the whole transfer.
- StartFlag  out  1  one-cycle start pulse to the master.
- Master_RxData  in  DATA_W  word from the SPI master.
- SPI_Done  in  1  master completion; a rising edge marks done.
- Busy  out  1  asserted in any state other than IDLE.
- Timeout  out  1  sticky watchdog flag.

Function
REQ-006 SHALL push Tx_Data into the TX FIFO on any cycle where Tx_Valid and Tx_Ready are both 1; a write while full SHALL be ignored.
REQ-007 SHALL pop the RX FIFO on any cycle where Rx_Valid and Rx_Ready are both 1; Rx_Data SHALL be first-word fall-through.
REQ-008 SHALL implement the FSM IDLE -> LOAD -> START -> WAIT_DONE -> CAPTURE -> GAP -> IDLE.
REQ-009 IDLE SHALL move to LOAD only when EN=1, the TX FIFO is non-empty and the RX FIFO is not full; otherwise it SHALL hold.
REQ-010 LOAD SHALL pop the TX head into the Master_TxData register.
REQ-011 START SHALL assert StartFlag for exactly one cycle, which is the cycle after LOAD.
REQ-012 WAIT_DONE SHALL exit on the first cycle where SPI_Done is 1 and SPI_Done was 0 on the previous cycle.
REQ-013 CAPTURE SHALL push Master_RxData into the RX FIFO; space for this push is guaranteed by REQ-009.
REQ-014 GAP SHALL count GAP_CYCLES cycles; with GAP_CYCLES=0 it SHALL last one cycle.
REQ-015 Throughput SHALL be one transfer per (SPI time + GAP_CYCLES + 4) cycles.
REQ-016 EN falling mid-transfer SHALL NOT abort the transfer; it only blocks the next exit from IDLE.
REQ-017 A simultaneous TX push in the LOAD cycle SHALL be accepted correctly, including when the FIFO holds a single entry.
REQ-018 A simultaneous RX pop in the CAPTURE cycle SHALL be accepted correctly, including when the FIFO is full-1.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH.
REQ-020 Full and empty SHALL be distinguished using one extra pointer bit.

Reset
REQ-021 While RST_N=0, the following SHALL be forced asynchronously:
- FSM state to IDLE.
- Both FIFOs to empty.
- Master_TxData to 0.
- StartFlag, Busy and Timeout to 0.
- Tx_Ready to 1 and Rx_Valid to 0.
- The gap/watchdog counter and the SPI_Done edge register to 0.
REQ-022 Reset mid-transfer SHALL discard the in-flight word; no RX push SHALL occur.

Configuration
REQ-023 With SPI_CMD_QUEUE_TIMEOUT_EN defined, WAIT_DONE SHALL count cycles. On reaching TIMEOUT_CYCLES it SHALL:
- set Timeout sticky until reset;
- push no RX word;
- go to GAP.
REQ-024 Without SPI_CMD_QUEUE_TIMEOUT_EN, WAIT_DONE SHALL wait indefinitely, Timeout SHALL be tied to 0, and no watchdog logic SHALL exist.

Structure
REQ-025 The shared package spi_pkg SHALL hold the FSM state enum and the default DATA_W and DEPTH constants.
REQ-026 Both FIFOs SHALL be instances of one sub-module, spi_sync_fifo, which uses the same clock and reset.

Verification
REQ-027 Reset, then write 16'hA9A5 with the loopback slave returning 16'hF0A5:
- StartFlag pulses once, 2 cycles after the write.
- Master_TxData=16'hA9A5 for the whole transfer.
- Rx_Data=16'hF0A5 with Rx_Valid=1.
REQ-028 Burst of 8 writes with Rx_Ready=0:
- Tx_Ready drops after the 8th write.
- 8 transfers complete.
- Rx_Valid stays 1.
- A 9th queued word does not start until one RX pop occurs.
REQ-029 Two queued words with GAP_CYCLES=4: exactly 4 idle cycles lie between the GAP entry and the IDLE re-entry before the second StartFlag.
REQ-030 EN=0 with 3 words queued: no StartFlag; on EN=1, 3 transfers complete in order.
REQ-031 RST_N pulsed during WAIT_DONE: outputs return to reset values immediately, RX FIFO is empty, and no capture follows.
REQ-032 With SPI_CMD_QUEUE_TIMEOUT_EN, TIMEOUT_CYCLES=16 and SPI_Done held 0: Timeout=1 after 16 cycles, Rx_Valid=0, and the FSM returns to IDLE.
